// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master.
// FSM state enum plus mode bit indices and mode encodings.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

  // bit positions inside the 2-bit mode word {CPOL,CPHA}
  localparam int SPI_CPOL = 1;
  localparam int SPI_CPHA = 0;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: counts CLK_DIV clk cycles, single-cycle tick_o.
// Ports: clk_i, rst_i (sync high), clr_i (sync clear), tick_o.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 34
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI master, all CPOL/CPHA modes, N slave selects.
// Ports: start/mode/ss_sel/wr_data in, rd_data/busy/done out, SCLK/SS/MOSI/MISO.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 34,
  parameter int NUM_SS     = 1,
  parameter int SS_SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [SS_SEL_W-1:0]   ss_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic [NUM_SS-1:0]     SS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_WIDTH);

  spi_state_e            state_q, state_d;
  logic                  cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic [NUM_SS-1:0]     ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  tick;
  logic [EW-1:0]         k;
  logic                  smp;
  logic                  shf;
  logic [NUM_SS-1:0]     ss_dec;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (accept),
    .tick_o (tick)
  );

  // out-of-range ss_sel leaves every line deasserted
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      ss_dec[i] = (ss_sel != SS_SEL_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    // k is the number of the edge the next tick produces
    k   = edge_q + EW'(1);
    smp = k[0] ^ cpha_q;
    // first CPHA=1 edge and last CPHA=0 edge never shift tx
    shf = cpha_q ? (k != EW'(1)) : (k != LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_LEAD;
          cpha_d  = mode[SPI_CPHA];
          tx_d    = wr_data;
          rx_d    = '0;
          edge_d  = '0;
          sclk_d  = mode[SPI_CPOL];
          ss_d    = ss_dec;
          busy_d  = 1'b1;
        end
      end
      ST_LEAD, ST_XFER: begin
        if (tick) begin
          edge_d = k;
          sclk_d = ~sclk_q;
          if (smp) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], MISO};
          end else if (shf) begin
            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          state_d = (k == LAST) ? ST_TRAIL : ST_XFER;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          ss_d    = '1;
          tx_d    = '0;
          rd_d    = rx_q;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // MOSI is tx MSB; tx is cleared at frame end so idle MOSI is 0
  assign MOSI    = tx_q[DATA_WIDTH-1];
  assign SCLK    = sclk_q;
  assign SS      = ss_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench with a behavioural SPI slave.
// Random frames, mode/select corners, back-to-back and reset.
module tb_spi_master;

  localparam int W  = 16;
  localparam int CD = 4;
  localparam int NS = 3;
  localparam int T_DONE = 1 + (2 * W + 1) * CD;
  localparam int T_BUSY = 1 + (2 * W + 2) * CD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [1:0]    ss_sel = 2'b00;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          SCLK;
  logic [NS-1:0] SS;
  logic          MOSI;
  logic          MISO = 1'b1;

  spi_master #(
    .DATA_WIDTH (W),
    .CLK_DIV    (CD),
    .NUM_SS     (NS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .ss_sel  (ss_sel),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .SCLK    (SCLK),
    .SS      (SS),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t0;
    logic [1:0] md;
    logic [1:0] ss;
    logic [W-1:0] wr;
    logic [W-1:0] rd;
  } item_t;

  item_t q[$];
  int n_chk = 0;
  int n_err = 0;
  bit mon_hold = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [1:0]   slv_mode = 2'b00;
  logic [W-1:0] slv_word = '0;
  logic [W-1:0] s_sh;
  logic [W-1:0] s_cap = '0;
  int           s_edges;
  logic         s_sel;
  logic         s_psel = 1'b0;
  logic         s_psclk = 1'b0;

  always @(negedge clk) begin
    s_sel = ~(&SS);
    if (s_sel && !s_psel) begin
      s_edges = 0;
      s_sh    = slv_word;
      s_cap   = '0;
      if (!slv_mode[0]) MISO = s_sh[W-1];
    end else if (s_sel && SCLK != s_psclk) begin
      s_edges++;
      if (!slv_mode[0]) begin
        if (s_edges % 2 == 1) s_cap = {s_cap[W-2:0], MOSI};
        else begin
          s_sh = s_sh << 1;
          MISO = s_sh[W-1];
        end
      end else begin
        if (s_edges % 2 == 1) begin
          MISO = s_sh[W-1];
          s_sh = s_sh << 1;
        end else s_cap = {s_cap[W-2:0], MOSI};
      end
    end
    if (!s_sel) MISO = 1'b1;
    s_psel  = s_sel;
    s_psclk = SCLK;
  end

  // ---------------- monitor ----------------
  logic          m_busy = 1'b0;
  logic          m_sclk = 1'b0;
  logic          m_mosi = 1'b0;
  logic          m_ssall = 1'b1;
  logic [NS-1:0] ss_and;
  int            tog;
  bit            glitch;
  int            ss_run = 0;
  bit            had_frame = 1'b0;
  int            bfall_exp = 0;
  item_t         it;
  logic [NS-1:0] emask;

  always @(negedge clk) begin
    if (!mon_hold) begin
      if (busy && !m_busy) begin
        ss_and = SS;
        tog    = 0;
        glitch = 1'b0;
      end else if (busy) begin
        ss_and = ss_and & SS;
        if (SCLK != m_sclk) tog++;
        if (MOSI != m_mosi && !done) begin
          if (SCLK == m_sclk) glitch = 1'b1;
          else if (q.size() > 0 &&
                   ((tog % 2 == 1) == (q[0].md[0] == 1'b0)))
            glitch = 1'b1;
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          it = q.pop_front();
          emask = '1;
          if (it.ss < 2'(NS)) emask[it.ss] = 1'b0;
          chk("done_time", cyc, it.t0 + T_DONE);
          chk("rd_data", rd_data, it.rd);
          if (it.ss < 2'(NS)) chk("mosi_capture", s_cap, it.wr);
          chk("ss_mask", ss_and, emask);
          chk("sclk_edges", tog, 2 * W);
          chk("sclk_idle", SCLK, it.md[1]);
          chk("mosi_stable", glitch, 0);
          chk("ss_high_at_done", SS, 3'b111);
          bfall_exp = it.t0 + T_BUSY;
        end
      end
      if (m_busy && !busy) chk("busy_fall", cyc, bfall_exp);
      if (m_ssall && !(&SS)) begin
        if (had_frame) chk("ss_gap_ok", ss_run >= CD + 1, 1);
        had_frame = 1'b1;
      end
    end
    if (&SS) ss_run++;
    else ss_run = 0;
    m_busy  = busy;
    m_sclk  = SCLK;
    m_mosi  = MOSI;
    m_ssall = &SS;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] m, input logic [1:0] s,
                       input logic [W-1:0] w, input logic [W-1:0] sw,
                       input bit hold, output int t0);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 0);
    mode     = m;
    ss_sel   = s;
    wr_data  = w;
    slv_mode = m;
    slv_word = sw;
    start    = 1'b1;
    t0       = cyc;
    q.push_back('{t0: cyc, md: m, ss: s, wr: w,
                  rd: (s < 2'(NS)) ? sw : {W{1'b1}}});
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic junk_pulse();
    repeat ($urandom_range(5, 100)) @(negedge clk);
    mode    = 2'($urandom);
    ss_sel  = 2'($urandom);
    wr_data = W'($urandom);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
    int t0;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ss", SS, 3'b111);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd_data, 0);
    reset = 1'b0;
    @(negedge clk);
    mon_hold = 1'b0;

    issue(2'b00, 2'd0, 16'hA5C3, 16'hA5C3, 1'b0, t0);
    issue(2'b11, 2'd0, 16'h5A5A, 16'h1234, 1'b0, t0);
    issue(2'b01, 2'd0, 16'h8001, 16'h8001, 1'b0, t0);
    issue(2'b10, 2'd0, 16'h8001, 16'h8001, 1'b0, t0);
    issue(2'b00, 2'd2, 16'h0F0F, 16'hC001, 1'b0, t0);
    issue(2'b11, 2'd3, 16'hFFFF, 16'h0000, 1'b0, t0);

    for (int i = 0; i < 16; i++) begin
      issue(2'($urandom), 2'($urandom), W'($urandom), W'($urandom),
            1'b0, t0);
      if ($urandom_range(0, 1) == 1) junk_pulse();
    end

    for (int i = 0; i < 3; i++) begin
      issue(2'($urandom), 2'($urandom_range(0, 2)), W'($urandom),
            W'($urandom), (i < 2), t0);
    end

    issue(2'b00, 2'd0, 16'hBEEF, 16'h3C3C, 1'b0, t0);
    while (cyc < t0 + 1 + 10 * CD) @(negedge clk);
    mon_hold = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ss", SS, 3'b111);
    chk("mid_rst_sclk", SCLK, 0);
    chk("mid_rst_mosi", MOSI, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", rd_data, 0);
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    mon_hold = 1'b0;
    repeat (150) @(negedge clk);

    issue(2'b00, 2'd1, 16'h1357, 16'h2468, 1'b0, t0);

    n = 0;
    while ((q.size() > 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised, fully synchronous SPI master that replaces the fixed 16-bit, mode-0, single-slave SPI controller. It generates SCLK from a `clk` divider and supports all four CPOL/CPHA modes, a configurable word width and multiple active-low slave selects. It exposes a start/busy/done handshake to the local bus side. It sits between a register/bus-attached controller and off-chip SPI peripherals (ADCs, flash, sensors).

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per frame, ≥2.
- `CLK_DIV`, 34: `clk` cycles per SCLK half-period, ≥2.
- `NUM_SS`, 1: number of slave-select lines, ≥1.
- `SS_SEL_W`, `max(1,$clog2(NUM_SS))`: width of `ss_sel`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  transfer request; accepted only when `busy`=0.
- `mode`  in  2  {CPOL,CPHA}; sampled when `start` is accepted.
- `ss_sel`  in  SS_SEL_W  target slave; sampled when `start` is accepted.
- `wr_data`  in  DATA_WIDTH  transmit word, MSB first; sampled when `start` is accepted.
- `rd_data`  out  DATA_WIDTH  last received word; updated only with `done`.
- `busy`  out  1  high from the cycle after acceptance to the end of GAP.
- `done`  out  1  one-cycle pulse when frame completes.
- `SCLK`  out  1  SPI clock.
- `SS`  out  NUM_SS  active-low selects.
- `MOSI`  out  1  serial data out.
- `MISO`  in  1  serial data in.

## Operation
- States: IDLE, LEAD, XFER, TRAIL, GAP.
- IDLE + `start`=1 (cycle T0):
  - latch `mode`, `ss_sel`, `wr_data` into the tx shifter;
  - clear edge counter and divider;
  - go to LEAD.
- LEAD: `SS[ss_sel]`=0, `SCLK`=CPOL, `MOSI`=tx MSB. Lasts CLK_DIV cycles, then XFER.
- XFER: every CLK_DIV cycles `SCLK` toggles (edge k=1..2·DATA_WIDTH). Odd k are leading edges, even k are trailing edges.
  - CPHA=0: sample `MISO` into rx LSB (shift left) on odd k. Shift tx on even k=2..2W−2.
  - CPHA=1: shift tx on odd k=3..2W−1. Sample on even k.
  - `MOSI` always equals the tx shifter MSB.
  - After edge 2W, go to TRAIL.
- TRAIL: `SCLK`=CPOL, `SS` still low, CLK_DIV cycles. On exit:
  - all `SS`=1, `MOSI`=0;
  - `rd_data`←rx shifter, `done`=1 for one cycle;
  - go to GAP.
- GAP: CLK_DIV cycles of all-`SS` high, then IDLE, `busy`=0.
- `start` in any non-IDLE state is ignored; no queueing.
- `ss_sel` ≥ NUM_SS: no `SS` line asserted. The transfer still runs and `done` still fires.
- `SCLK` in IDLE/GAP holds the CPOL of the last accepted transfer. It changes only on a new acceptance, while all `SS` are high.
- MISO is sampled directly, with no synchronizer. Slaves must meet setup/hold to `clk` at the sample cycle.

## Timing
- Reset values: `SS`=all 1, `SCLK`=0, `MOSI`=0, `busy`=0, `done`=0, `rd_data`=0, state IDLE.
- Reset takes priority in any state. Mid-frame reset returns all outputs to reset values on the next edge, with no `done`.
- Edge k registered at T0+1+k·CLK_DIV. `SS` falls at T0+1.
- `done` and `SS` rise at T0+1+(2W+1)·CLK_DIV.
- `busy` falls at T0+1+(2W+2)·CLK_DIV.
- Earliest next acceptance is that same cycle, giving minimum SS-high time CLK_DIV+1.
- Sample/shift actions occur in the same cycle the `SCLK` register toggles. The shifted `MOSI` appears with the toggled `SCLK`.

## Structure
- Package `spi_pkg`:
  - state enum;
  - mode index constants `SPI_CPOL`=1, `SPI_CPHA`=0;
  - mode constants `SPI_MODE0..3`.
- One sub-module `spi_clk_div`: a CLK_DIV counter producing a single-cycle `tick`, with synchronous clear on acceptance.
- Top: FSM, edge counter ($clog2(2W+1) bits), tx/rx shifters, SS decoder.

## Test plan
- Common parameters unless noted: W=16, CLK_DIV=4, NUM_SS=1.
- Mode 0, `wr_data`=16'hA5C3, MOSI looped to MISO → `rd_data`=16'hA5C3. 16 rising edges, `done` at T0+133, `busy` low at T0+137.
- Mode 3, slave model shifts 16'h1234 on falling edges → `rd_data`=16'h1234. `SCLK` high in LEAD/TRAIL/GAP. MOSI changes only on falling edges.
- Modes 1 and 2 with `wr_data`=16'h8001 and a checker slave → MOSI stable at every sample edge, received 16'h8001 both ways.
- `start` held high continuously → back-to-back frames, `SS` high ≥5 cycles between them. Pulses on `start` during XFER are ignored (exactly one `done` per accepted frame).
- NUM_SS=3:
  - `ss_sel`=2 → only `SS[2]` low;
  - `ss_sel`=3 → `SS`=3'b111 throughout, `done` still pulses.
- `reset` asserted at edge 10 of a mode-0 frame → next cycle `SS`=1, `SCLK`=0, `MOSI`=0, `busy`=0, no `done`. A following start completes normally.
